loom_axi4_addr_demux: RTL
=========================

// Module: loom_axi4_addr_demux
// PURPOSE
//   1-to-2 AXI4 address demux in front of the DECERR error slave. Decodes each AW/AR
//   against one address window: hits route to m0 (real target), misses to m1 (error slave).
//   W/B/R are steered back by the latched decision. One outstanding txn per channel;
//   read and write paths fully independent.
// PARAMETERS
//   ID_WIDTH    4            AXI ID width, all ports
//   DATA_WIDTH  128          AXI data width, all ports
//   ADDR_BASE   64'h0        window base; hit = (addr & ADDR_MASK) == ADDR_BASE
//   ADDR_MASK   64'hFFFF_FFFF_F000_0000   window mask
// PORTS
//   clk_i         in   1    clock
//   rst_ni        in   1    async reset, active low
//   s_axi_aw*     in/out    AW slave bundle (id,addr[63:0],len[7:0],size,burst,lock,cache,prot,valid / ready)
//   s_axi_w*      in/out    W slave bundle (data,strb[DATA_WIDTH/8],last,valid / ready)
//   s_axi_b*      out/in    B slave bundle (id,resp[1:0],valid / ready)
//   s_axi_ar*     in/out    AR slave bundle, same fields as AW
//   s_axi_r*      out/in    R slave bundle (id,data,resp,last,valid / ready)
//   m0_axi_*      mirror    master bundle to in-window target, all five channels
//   m1_axi_*      mirror    master bundle to error slave, all five channels
// BEHAVIOUR
//   - Reset (rst_ni low): wr FSM=WrIdle, rd FSM=RdIdle, sel regs=0; every valid/ready output forced 0.
//   - Zero-latency combinational pass-through; only select and FSM state are registered.
//   - Unselected master port: all valids 0; all payload fields driven to the slave values (don't care).
//   - Write FSM:
//       WrIdle: aw_sel = miss(s_axi_awaddr); mX_awvalid = s_axi_awvalid for X=aw_sel,
//               s_axi_awready = mX_awready. AW handshake -> latch wr_sel_q, -> WrData.
//               s_axi_wready=0, s_axi_bvalid=0 (W beats before AW are back-pressured).
//       WrData: W routed to wr_sel_q port; handshake with wlast=1 -> WrResp. AW ready=0.
//       WrResp: B from wr_sel_q port to slave; other port bready=0; B handshake -> WrIdle.
//   - Read FSM:
//       RdIdle: AR routed by miss(s_axi_araddr) exactly as AW; handshake -> latch rd_sel_q, -> RdData.
//       RdData: R from rd_sel_q port; s_axi_arready=0; R handshake with rlast=1 -> RdIdle.
//   - AR and AW in same cycle: both accepted independently, may select different ports.
//   - Decode uses full 64-bit address; no partial compare. IDs pass through unmodified.
//   - Decode evaluated every cycle while valid and not ready; downstream stability is upstream's job.
//   - Reset mid-burst: FSMs return to Idle immediately, no residual beats or responses.
//   - Single-beat bursts (len=0): WrData/RdData each last exactly one handshake.
// CONFIGURATION
//   LOOM_AXI4_DEMUX_STATS_EN defined: adds outputs err_wr_cnt_o[15:0], err_rd_cnt_o[15:0];
//     +1 on each AW / AR handshake routed to m1; saturate at 16'hFFFF; reset 0.
//   Not defined: ports and counters absent; routing behaviour identical.
// TESTING
//   1. AW addr=ADDR_BASE+0x40 len=3, 4 W beats, m0 B OKAY -> m0 sees AW+4 W, s_axi_bresp=00, m1 idle.
//   2. AR addr=64'hDEAD_0000_0000 len=7 to m1=error slave -> 8 R beats resp=11, rlast on 8th, m0 idle.
//   3. Same-cycle AW hit + AR miss -> both handshake that cycle; B from m0, R from m1, no cross-talk.
//   4. W valid 3 cycles before AW -> s_axi_wready=0 until WrData; no beat lost or duplicated.
//   5. rst_ni low after 2 of 5 R beats -> all valids 0 at once; next AR accepted in RdIdle.
//   6. STATS_EN: 3 miss writes, 2 miss reads, 1 hit -> err_wr_cnt_o=3, err_rd_cnt_o=2; saturation check.

Source files
------------

// File: rtl/loom_axi4_addr_demux.sv
// 1-to-2 AXI4 address demux: in-window AW/AR go to m0, misses go to m1 (DECERR slave).
// Optional miss counters are enabled with LOOM_AXI4_DEMUX_STATS_EN.
module loom_axi4_addr_demux #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter logic [63:0] ADDR_BASE  = 64'h0,
  parameter logic [63:0] ADDR_MASK  = 64'hFFFF_FFFF_F000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
`ifdef LOOM_AXI4_DEMUX_STATS_EN
  output logic [15:0]             err_wr_cnt_o,
  output logic [15:0]             err_rd_cnt_o,
`endif
  // Slave side
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [63:0]             s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [63:0]             s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // Master 0: in-window target
  output logic [ID_WIDTH-1:0]     m0_axi_awid,
  output logic [63:0]             m0_axi_awaddr,
  output logic [7:0]              m0_axi_awlen,
  output logic [2:0]              m0_axi_awsize,
  output logic [1:0]              m0_axi_awburst,
  output logic                    m0_axi_awlock,
  output logic [3:0]              m0_axi_awcache,
  output logic [2:0]              m0_axi_awprot,
  output logic                    m0_axi_awvalid,
  input  logic                    m0_axi_awready,
  output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_wlast,
  output logic                    m0_axi_wvalid,
  input  logic                    m0_axi_wready,
  input  logic [ID_WIDTH-1:0]     m0_axi_bid,
  input  logic [1:0]              m0_axi_bresp,
  input  logic                    m0_axi_bvalid,
  output logic                    m0_axi_bready,
  output logic [ID_WIDTH-1:0]     m0_axi_arid,
  output logic [63:0]             m0_axi_araddr,
  output logic [7:0]              m0_axi_arlen,
  output logic [2:0]              m0_axi_arsize,
  output logic [1:0]              m0_axi_arburst,
  output logic                    m0_axi_arlock,
  output logic [3:0]              m0_axi_arcache,
  output logic [2:0]              m0_axi_arprot,
  output logic                    m0_axi_arvalid,
  input  logic                    m0_axi_arready,
  input  logic [ID_WIDTH-1:0]     m0_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic [1:0]              m0_axi_rresp,
  input  logic                    m0_axi_rlast,
  input  logic                    m0_axi_rvalid,
  output logic                    m0_axi_rready,
  // Master 1: error slave
  output logic [ID_WIDTH-1:0]     m1_axi_awid,
  output logic [63:0]             m1_axi_awaddr,
  output logic [7:0]              m1_axi_awlen,
  output logic [2:0]              m1_axi_awsize,
  output logic [1:0]              m1_axi_awburst,
  output logic                    m1_axi_awlock,
  output logic [3:0]              m1_axi_awcache,
  output logic [2:0]              m1_axi_awprot,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wlast,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [ID_WIDTH-1:0]     m1_axi_bid,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ID_WIDTH-1:0]     m1_axi_arid,
  output logic [63:0]             m1_axi_araddr,
  output logic [7:0]              m1_axi_arlen,
  output logic [2:0]              m1_axi_arsize,
  output logic [1:0]              m1_axi_arburst,
  output logic                    m1_axi_arlock,
  output logic [3:0]              m1_axi_arcache,
  output logic [2:0]              m1_axi_arprot,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [ID_WIDTH-1:0]     m1_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rlast,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
  typedef enum logic       {RdIdle, RdData} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic      wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic      aw_miss, ar_miss;

  assign aw_miss = (s_axi_awaddr & ADDR_MASK) != ADDR_BASE;
  assign ar_miss = (s_axi_araddr & ADDR_MASK) != ADDR_BASE;

  // Payloads fan out to both masters unconditionally; only valids are steered.
  assign {m0_axi_awid, m0_axi_awaddr, m0_axi_awlen, m0_axi_awsize, m0_axi_awburst,
          m0_axi_awlock, m0_axi_awcache, m0_axi_awprot} =
         {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
          s_axi_awlock, s_axi_awcache, s_axi_awprot};
  assign {m1_axi_awid, m1_axi_awaddr, m1_axi_awlen, m1_axi_awsize, m1_axi_awburst,
          m1_axi_awlock, m1_axi_awcache, m1_axi_awprot} =
         {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
          s_axi_awlock, s_axi_awcache, s_axi_awprot};
  assign {m0_axi_arid, m0_axi_araddr, m0_axi_arlen, m0_axi_arsize, m0_axi_arburst,
          m0_axi_arlock, m0_axi_arcache, m0_axi_arprot} =
         {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
          s_axi_arlock, s_axi_arcache, s_axi_arprot};
  assign {m1_axi_arid, m1_axi_araddr, m1_axi_arlen, m1_axi_arsize, m1_axi_arburst,
          m1_axi_arlock, m1_axi_arcache, m1_axi_arprot} =
         {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
          s_axi_arlock, s_axi_arcache, s_axi_arprot};
  assign {m0_axi_wdata, m0_axi_wstrb, m0_axi_wlast} = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign {m1_axi_wdata, m1_axi_wstrb, m1_axi_wlast} = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};

  assign s_axi_bid   = wr_sel_q ? m1_axi_bid   : m0_axi_bid;
  assign s_axi_bresp = wr_sel_q ? m1_axi_bresp : m0_axi_bresp;
  assign s_axi_rid   = rd_sel_q ? m1_axi_rid   : m0_axi_rid;
  assign s_axi_rdata = rd_sel_q ? m1_axi_rdata : m0_axi_rdata;
  assign s_axi_rresp = rd_sel_q ? m1_axi_rresp : m0_axi_rresp;
  assign s_axi_rlast = rd_sel_q ? m1_axi_rlast : m0_axi_rlast;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  // Handshake outputs are gated by rst_ni so nothing leaks while reset is held.
  always_comb begin
    wr_state_d     = wr_state_q;
    wr_sel_d       = wr_sel_q;
    m0_axi_awvalid = 1'b0;
    m1_axi_awvalid = 1'b0;
    s_axi_awready  = 1'b0;
    m0_axi_wvalid  = 1'b0;
    m1_axi_wvalid  = 1'b0;
    s_axi_wready   = 1'b0;
    s_axi_bvalid   = 1'b0;
    m0_axi_bready  = 1'b0;
    m1_axi_bready  = 1'b0;
    if (rst_ni) begin
      unique case (wr_state_q)
        WrIdle: begin
          m0_axi_awvalid = s_axi_awvalid & ~aw_miss;
          m1_axi_awvalid = s_axi_awvalid & aw_miss;
          s_axi_awready  = aw_miss ? m1_axi_awready : m0_axi_awready;
          if (s_axi_awvalid && s_axi_awready) begin
            wr_sel_d   = aw_miss;
            wr_state_d = WrData;
          end
        end
        WrData: begin
          m0_axi_wvalid = s_axi_wvalid & ~wr_sel_q;
          m1_axi_wvalid = s_axi_wvalid & wr_sel_q;
          s_axi_wready  = wr_sel_q ? m1_axi_wready : m0_axi_wready;
          if (s_axi_wvalid && s_axi_wready && s_axi_wlast) wr_state_d = WrResp;
        end
        WrResp: begin
          s_axi_bvalid  = wr_sel_q ? m1_axi_bvalid : m0_axi_bvalid;
          m0_axi_bready = s_axi_bready & ~wr_sel_q;
          m1_axi_bready = s_axi_bready & wr_sel_q;
          if (s_axi_bvalid && s_axi_bready) wr_state_d = WrIdle;
        end
        default: wr_state_d = WrIdle;
      endcase
    end
  end

  always_comb begin
    rd_state_d     = rd_state_q;
    rd_sel_d       = rd_sel_q;
    m0_axi_arvalid = 1'b0;
    m1_axi_arvalid = 1'b0;
    s_axi_arready  = 1'b0;
    s_axi_rvalid   = 1'b0;
    m0_axi_rready  = 1'b0;
    m1_axi_rready  = 1'b0;
    if (rst_ni) begin
      unique case (rd_state_q)
        RdIdle: begin
          m0_axi_arvalid = s_axi_arvalid & ~ar_miss;
          m1_axi_arvalid = s_axi_arvalid & ar_miss;
          s_axi_arready  = ar_miss ? m1_axi_arready : m0_axi_arready;
          if (s_axi_arvalid && s_axi_arready) begin
            rd_sel_d   = ar_miss;
            rd_state_d = RdData;
          end
        end
        RdData: begin
          s_axi_rvalid  = rd_sel_q ? m1_axi_rvalid : m0_axi_rvalid;
          m0_axi_rready = s_axi_rready & ~rd_sel_q;
          m1_axi_rready = s_axi_rready & rd_sel_q;
          if (s_axi_rvalid && s_axi_rready && s_axi_rlast) rd_state_d = RdIdle;
        end
        default: rd_state_d = RdIdle;
      endcase
    end
  end

`ifdef LOOM_AXI4_DEMUX_STATS_EN
  logic [15:0] err_wr_cnt_q, err_rd_cnt_q;
  logic        aw_err_hs, ar_err_hs;

  assign aw_err_hs = s_axi_awvalid & s_axi_awready & aw_miss;
  assign ar_err_hs = s_axi_arvalid & s_axi_arready & ar_miss;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_wr_cnt_q <= 16'h0;
      err_rd_cnt_q <= 16'h0;
    end else begin
      if (aw_err_hs && err_wr_cnt_q != 16'hFFFF) err_wr_cnt_q <= err_wr_cnt_q + 16'h1;
      if (ar_err_hs && err_rd_cnt_q != 16'hFFFF) err_rd_cnt_q <= err_rd_cnt_q + 16'h1;
    end
  end

  assign err_wr_cnt_o = err_wr_cnt_q;
  assign err_rd_cnt_o = err_rd_cnt_q;
`endif

endmodule
